// File: rtl/cnt_display_7seg_pkg.sv
// cnt_display_pkg: shared FSM state type, blank-segment constant and 0-9 segment table (a=bit0..g=bit6, active-high)
package cnt_display_pkg;
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
  localparam logic [6:0] SEG_OFF = 7'h00;
  localparam logic [6:0] SEG_TAB [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, SEG_OFF, SEG_OFF, SEG_OFF, SEG_OFF, SEG_OFF, SEG_OFF
  };
  function automatic logic [6:0] seg_encode(input logic [3:0] n);
    return SEG_TAB[n];
  endfunction
endpackage

// File: rtl/cnt_display_7seg_if.sv
// cnt_display_7seg_if: count input, 7-segment bus, digit enables, BCD digits and busy flag
//   slave  (display side): in cnt_in; out seg, an, bcd_tens, bcd_ones, busy
//   master (source side) : out cnt_in; in seg, an, bcd_tens, bcd_ones, busy
interface cnt_display_7seg_if;
  logic [5:0] cnt_in;
  logic [6:0] seg;
  logic [1:0] an;
  logic [3:0] bcd_tens;
  logic [3:0] bcd_ones;
  logic       busy;
  modport slave (input cnt_in, output seg, an, bcd_tens, bcd_ones, busy);
  modport master (output cnt_in, input seg, an, bcd_tens, bcd_ones, busy);
endinterface

// File: rtl/cnt_display_7seg_bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-add-3 conversion of a 6-bit value into tens/ones BCD
//   clk, rst (sync, active-high), bin[5:0] in; bcd_tens[3:0], bcd_ones[3:0], busy out
module bin2bcd_seq
  import cnt_display_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] bin,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones,
  output logic       busy
);
  state_t state, state_nxt;
  logic [13:0] sh, sh_adj;
  logic [5:0] last_cnt;
  logic [2:0] iter;
  logic start;
  always_comb begin
    start = state == IDLE && bin != last_cnt;
    sh_adj = sh;
    sh_adj[13:10] = sh[13:10] >= 4'd5 ? sh[13:10] + 4'd3 : sh[13:10];
    sh_adj[9:6] = sh[9:6] >= 4'd5 ? sh[9:6] + 4'd3 : sh[9:6];
    state_nxt = state == IDLE ? (start ? CONV : IDLE) :
                state == CONV ? (iter == 3'd5 ? DONE : CONV) : IDLE;
  end
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nxt;
  always_ff @(posedge clk) begin
    if (rst) begin
      sh <= '0;
      last_cnt <= '0;
      iter <= '0;
      busy <= 1'b0;
      bcd_tens <= '0;
      bcd_ones <= '0;
    end else begin
      if (start) begin
        sh <= {8'd0, bin};
        last_cnt <= bin;
        iter <= '0;
        busy <= 1'b1;
      end
      if (state == CONV) begin
        sh <= {sh_adj[12:0], 1'b0};
        iter <= iter + 3'd1;
      end
      if (state == DONE) begin
        bcd_tens <= sh[13:10];
        bcd_ones <= sh[9:6];
        busy <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/cnt_display_7seg.sv
// cnt_display_7seg: converts a 0..63 count to BCD and time-multiplexes both digits onto one 7-segment bus
//   clk, rst (sync, active-high); bus (slave): cnt_in in; seg, an, bcd_tens, bcd_ones, busy out
//   Optional LEADING_ZERO_BLANK_EN: blank the tens slot when the tens digit is 0.
module cnt_display_7seg
  import cnt_display_pkg::*;
#(
  parameter int SCAN_DIV   = 25000,
  parameter bit SEG_ACT_LO = 1'b1
) (
  input logic clk,
  input logic rst,
  cnt_display_7seg_if.slave bus
);
  localparam int PW = $clog2(SCAN_DIV);
  logic [PW-1:0] pres;
  logic digit_sel;
  logic nxt_sel;
  logic tick;
  logic blank;
  logic [3:0] nib;
  logic [6:0] seg_hi;
  logic [1:0] an_hi;
  bin2bcd_seq u_conv (
    .clk      (clk),
    .rst      (rst),
    .bin      (bus.cnt_in),
    .bcd_tens (bus.bcd_tens),
    .bcd_ones (bus.bcd_ones),
    .busy     (bus.busy)
  );
  // digit_sel=1 selects the ones digit; reset leaves 0 so the first slot shows ones
  always_comb begin
    tick = pres == PW'(SCAN_DIV - 1);
    nxt_sel = ~digit_sel;
    nib = nxt_sel ? bus.bcd_ones : bus.bcd_tens;
`ifdef LEADING_ZERO_BLANK_EN
    blank = !nxt_sel && bus.bcd_tens == 4'd0;
`else
    blank = 1'b0;
`endif
    seg_hi = blank ? SEG_OFF : seg_encode(nib);
    an_hi = blank ? 2'b00 : nxt_sel ? 2'b01 : 2'b10;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pres <= '0;
      digit_sel <= 1'b0;
      bus.seg <= SEG_ACT_LO ? ~SEG_OFF : SEG_OFF;
      bus.an <= SEG_ACT_LO ? 2'b11 : 2'b00;
    end else if (tick) begin
      pres <= '0;
      digit_sel <= nxt_sel;
      bus.seg <= SEG_ACT_LO ? ~seg_hi : seg_hi;
      bus.an <= SEG_ACT_LO ? ~an_hi : an_hi;
    end else begin
      pres <= pres + 1'b1;
    end
  end
endmodule

// File: tb/tb_cnt_display_7seg.sv
// tb_cnt_display_7seg: directed and random stimulus against a cycle-level behavioural model
module tb_cnt_display_7seg;
  localparam int SD = 4;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif
  localparam logic [6:0] LO_TAB [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic chk_en = 1'b0;
  int checks = 0;
  int errors = 0;
  int m_last, m_val, m_timer, m_tens, m_ones, m_cyc;
  logic [6:0] m_seg;
  logic [1:0] m_an;
  cnt_display_7seg_if bus();
  cnt_display_7seg #(.SCAN_DIV(SD), .SEG_ACT_LO(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wait_ones();
    int n = 0;
    while (bus.an == 2'b10 && n < 20) begin step(1); n++; end
    while (bus.an != 2'b10 && n < 20) begin step(1); n++; end
  endtask
  // Model: a conversion takes 7 edges from the sampling edge; the display refreshes every SD edges
  always @(posedge clk) begin
    if (rst) begin
      m_last = 0; m_val = 0; m_timer = 0; m_tens = 0; m_ones = 0; m_cyc = 0;
      m_seg = 7'h7F; m_an = 2'b11;
    end else begin
      m_cyc++;
      if (m_cyc % SD == 0) begin
        if ((m_cyc / SD) % 2 == 1) begin m_an = 2'b10; m_seg = LO_TAB[m_ones]; end
        else if (BLANK && m_tens == 0) begin m_an = 2'b11; m_seg = 7'h7F; end
        else begin m_an = 2'b01; m_seg = LO_TAB[m_tens]; end
      end
      if (m_timer > 0) begin
        m_timer--;
        if (m_timer == 0) begin m_tens = m_val / 10; m_ones = m_val % 10; end
      end else if (int'(bus.cnt_in) != m_last) begin
        m_last = int'(bus.cnt_in); m_val = m_last; m_timer = 7;
      end
    end
  end
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_seg", bus.seg, m_seg);
      chk("m_an", bus.an, m_an);
      chk("m_tens", bus.bcd_tens, m_tens);
      chk("m_ones", bus.bcd_ones, m_ones);
      chk("m_busy", bus.busy, m_timer > 0);
    end
  end
  initial begin
    bus.cnt_in = 6'd0;
    step(1);
    chk_en = 1'b1;
    step(2);
    chk("rst_seg", bus.seg, 7'h7F);
    chk("rst_an", bus.an, 2'b11);
    chk("rst_bcd", {bus.bcd_tens, bus.bcd_ones}, 8'h00);
    chk("rst_busy", bus.busy, 0);
    rst = 1'b0;
    step(3);
    chk("pre_tick_an", bus.an, 2'b11);
    step(1);
    chk("first_an", bus.an, 2'b10);
    chk("first_seg", bus.seg, 7'h40);
    bus.cnt_in = 6'd37;
    step(1);
    chk("c37_busy0", bus.busy, 1);
    step(6);
    chk("c37_busy6", bus.busy, 1);
    chk("c37_old", {bus.bcd_tens, bus.bcd_ones}, 8'h00);
    step(1);
    chk("c37_busy7", bus.busy, 0);
    chk("c37_bcd", {bus.bcd_tens, bus.bcd_ones}, 8'h37);
    wait_ones();
    chk("c37_ones_an", bus.an, 2'b10);
    chk("c37_ones_seg", bus.seg, 7'h78);
    step(SD);
    chk("c37_tens_an", bus.an, 2'b01);
    chk("c37_tens_seg", bus.seg, 7'h30);
    bus.cnt_in = 6'd63; step(8);
    chk("c63_bcd", {bus.bcd_tens, bus.bcd_ones}, 8'h63);
    bus.cnt_in = 6'd10; step(8);
    chk("c10_bcd", {bus.bcd_tens, bus.bcd_ones}, 8'h10);
    bus.cnt_in = 6'd0; step(8);
    chk("c0_bcd", {bus.bcd_tens, bus.bcd_ones}, 8'h00);
    bus.cnt_in = 6'd59; step(8);
    chk("c59_bcd", {bus.bcd_tens, bus.bcd_ones}, 8'h59);
    bus.cnt_in = 6'd10; step(2);
    bus.cnt_in = 6'd20; step(6);
    chk("skip_first", {bus.bcd_tens, bus.bcd_ones}, 8'h10);
    chk("skip_idle", bus.busy, 0);
    step(1);
    chk("skip_restart", bus.busy, 1);
    step(7);
    chk("skip_second", {bus.bcd_tens, bus.bcd_ones}, 8'h20);
    bus.cnt_in = 6'd45; step(3);
    rst = 1'b1; step(1); rst = 1'b0;
    chk("abort_bcd", {bus.bcd_tens, bus.bcd_ones}, 8'h00);
    chk("abort_busy", bus.busy, 0);
    bus.cnt_in = 6'd12; step(8);
    chk("after_abort", {bus.bcd_tens, bus.bcd_ones}, 8'h12);
    bus.cnt_in = 6'd7; step(8);
    wait_ones();
    chk("c7_ones_seg", bus.seg, 7'h78);
    step(SD);
    chk("c7_tens_an", bus.an, BLANK ? 2'b11 : 2'b01);
    chk("c7_tens_seg", bus.seg, BLANK ? 7'h7F : 7'h40);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) bus.cnt_in = 6'($urandom_range(0, 63));
      if (i == 200) rst = 1'b1;
      if (i == 202) rst = 1'b0;
      step(1);
    end
    step(10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
